// File: rtl/fact_mmio_accel.sv
// Memory-mapped iterative factorial accelerator on the data-memory bus.
// Ports: clk, rst (async active-low); we/a/wd bus write side;
// rd combinational read data; done_o mirrors the STATUS done bit.
// Register map by a: 0 = N (RW), 1 = GO (W) / busy (R),
// 2 = STATUS {err, done} (RO), 3 = RESULT (RO).
module fact_mmio_accel #(
    parameter int DW    = 32,
    parameter int NW    = 4,
    parameter int MAX_N = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [1:0]    a,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic          done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [NW-1:0] MAX_NW = NW'(MAX_N);
    localparam logic [NW-1:0] ONE_NW = NW'(1);

    state_t        state, state_nx;
    logic [NW-1:0] n_reg, n_nx;
    logic [NW-1:0] cnt, cnt_nx;
    logic [DW-1:0] result, res_nx;
    logic          done, done_nx;
    logic          err, err_nx;
    logic          busy, busy_nx;

    logic             go;
    logic [DW+NW-1:0] prod;

    // Upper write-data bits have no destination in this block.
    logic unused_wd;
    assign unused_wd = &{1'b0, wd[DW-1:NW]};

    assign go   = we && (a == 2'd1) && wd[0];
    assign prod = {{NW{1'b0}}, result} * {{DW{1'b0}}, cnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            n_reg  <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            n_reg  <= n_nx;
            cnt    <= cnt_nx;
            result <= res_nx;
            done   <= done_nx;
            err    <= err_nx;
            busy   <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        n_nx     = n_reg;
        cnt_nx   = cnt;
        res_nx   = result;
        done_nx  = done;
        err_nx   = err;
        busy_nx  = busy;

        // Gated by the registered busy, so a write landing on the
        // completion edge is still dropped.
        if (we && (a == 2'd0) && !busy) begin
            n_nx = wd[NW-1:0];
        end

        unique case (state)
            IDLE: begin
                if (go) begin
                    if (n_reg <= MAX_NW) begin
                        state_nx = CALC;
                        res_nx   = DW'(1);
                        cnt_nx   = n_reg;
                        busy_nx  = 1'b1;
                        done_nx  = 1'b0;
                        err_nx   = 1'b0;
                    end else begin
                        res_nx  = '0;
                        busy_nx = 1'b0;
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end
                end
            end
            CALC: begin
                if (cnt > ONE_NW) begin
                    res_nx = prod[DW-1:0];
                    cnt_nx = cnt - ONE_NW;
                end else begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd = '0;
        unique case (a)
            2'd0: rd = {{(DW-NW){1'b0}}, n_reg};
            2'd1: rd = {{(DW-1){1'b0}}, busy};
            2'd2: rd = {{(DW-2){1'b0}}, err, done};
            2'd3: rd = result;
            default: rd = '0;
        endcase
    end

    assign done_o = done;

endmodule

// File: tb/tb_fact_mmio_accel.sv
// Self-checking bench for fact_mmio_accel.
// Random and directed starts checked against a factorial model.
module tb_fact_mmio_accel;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        done_o;

    int n_cmp;
    int n_bad;

    fact_mmio_accel #(.DW(32), .NW(4), .MAX_N(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .a      (a),
        .wd     (wd),
        .rd     (rd),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input int n);
        longint p;
        p = 1;
        for (int i = 2; i <= n; i++) p = p * i;
        return p[31:0];
    endfunction

    function automatic int lat(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    // One bus write; returns 1 time unit after the write edge.
    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic rdr(input logic [1:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = rd;
    endtask

    // Counts edges until done_o, and cycles where busy read 1.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (done_o !== 1'b1 && edges < 200) begin
            a = 2'd1;
            #1;
            if (rd[0] === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_reg%0d got %h want 00000000", i, v);
            end
        end
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done_o got %b want 0", done_o);
        end
    endtask

    // Runs one start with N=n and checks against the model.
    task automatic test_start(input string tag, input int n);
        logic [31:0] v;
        int          e;
        int          b;
        wr(2'd0, 32'(n));
        wr(2'd1, 32'h1);
        if (n > 12) begin
            rdr(2'd2, v);
            n_cmp++;
            if (v !== 32'h3) begin
                n_bad++;
                $display("FAIL %s_status got %h want 3", tag, v);
            end
            rdr(2'd3, v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++;
                $display("FAIL %s_result got %h want 0", tag, v);
            end
            b = 0;
            for (int i = 0; i < 3; i++) begin
                rdr(2'd1, v);
                if (v[0] !== 1'b0) b++;
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (b != 0 || done_o !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_busy got %0d/%b want 0/1",
                         tag, b, done_o);
            end
        end else begin
            n_cmp++;
            if (done_o !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_done_clr got %b want 0", tag, done_o);
            end
            wait_done(e, b);
            n_cmp++;
            if (e != lat(n) || b != lat(n)) begin
                n_bad++;
                $display("FAIL %s_lat got %0d/%0d want %0d",
                         tag, e, b, lat(n));
            end
            rdr(2'd2, v);
            n_cmp++;
            if (v !== 32'h1) begin
                n_bad++;
                $display("FAIL %s_status got %h want 1", tag, v);
            end
            rdr(2'd3, v);
            n_cmp++;
            if (v !== fact(n)) begin
                n_bad++;
                $display("FAIL %s_result got %h want %h", tag, v, fact(n));
            end
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] v;
        test_start("nominal5", 5);
        test_start("n0", 0);
        test_start("n1", 1);
        test_start("n12", 12);
        rdr(2'd3, v);
        n_cmp++;
        if (v !== 32'h1C8CFC00) begin
            n_bad++;
            $display("FAIL n12_const got %h want 1c8cfc00", v);
        end
        test_start("err13", 13);
        test_start("err15", 15);
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 15);
            test_start($sformatf("rand%0d_n%0d", k, n), n);
        end
    endtask

    task automatic test_busy_protect;
        logic [31:0] v;
        int          e;
        int          b;
        wr(2'd0, 32'd6);
        wr(2'd1, 32'h1);
        @(posedge clk);
        #1;
        wr(2'd0, 32'd3);
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFFFF);
        wait_done(e, b);
        rdr(2'd0, v);
        n_cmp++;
        if (v !== 32'd6) begin
            n_bad++;
            $display("FAIL bp_n got %h want 6", v);
        end
        rdr(2'd3, v);
        n_cmp++;
        if (v !== 32'h2D0) begin
            n_bad++;
            $display("FAIL bp_result got %h want 2d0", v);
        end
        wr(2'd1, 32'h0);
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_go0 got done %b want 1", done_o);
        end
        test_start("bp_n3", 3);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(2'd0, 32'd10);
        wr(2'd1, 32'h1);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            rdr(2'(i), v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++;
                $display("FAIL rmid_reg%0d got %h want 0", i, v);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        test_start("rmid_n4", 4);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        we    = 1'b0;
        a     = 2'd0;
        wd    = '0;
        test_reset();
        test_boundaries();
        test_random();
        test_busy_protect();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
